// File: rtl/collision_pkg.sv
// Shared types and constants for the collision detector.
// Build option: COLLISION_MIDPOINT_EN adds four mid-edge probes (12 instead of 8).
package collision_pkg;

    localparam int CHAR_W_DEF        = 8;
    localparam int CHAR_H_DEF        = 16;
    localparam int TILE_SHIFT_DEF    = 3;
    localparam int MAP_COLS_LOG2_DEF = 6;
    localparam int MAP_ROWS_DEF      = 15;

    // Probe coordinates are signed so that -1 and edge+size never wrap.
    localparam int COORD_W = 11;
    localparam int WX_W    = 10;
    localparam int IDX_W   = 4;

`ifdef COLLISION_MIDPOINT_EN
    localparam int PROBE_COUNT = 12;
`else
    localparam int PROBE_COUNT = 8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    function automatic logic [3:0] dir_mask(input dir_e d);
        return 4'(1) << d;
    endfunction

endpackage

// File: rtl/collision_probe_gen.sv
// Maps a probe index and the coordinate snapshot to a tile address, an
// in-map flag, the forced result for off-map probes and the probe direction.
module collision_probe_gen
    import collision_pkg::*;
#(
    parameter int CHAR_W        = CHAR_W_DEF,
    parameter int CHAR_H        = CHAR_H_DEF,
    parameter int TILE_SHIFT    = TILE_SHIFT_DEF,
    parameter int MAP_COLS_LOG2 = MAP_COLS_LOG2_DEF,
    parameter int MAP_ROWS      = MAP_ROWS_DEF,
    parameter int ROW_W         = $clog2(MAP_ROWS)
) (
    input  logic [IDX_W-1:0]               idx_i,
    input  logic [WX_W-1:0]                wx_i,
    input  logic [7:0]                     y_i,
    output logic [ROW_W+MAP_COLS_LOG2-1:0] addr_o,
    output logic                           in_map_o,
    output logic                           forced_o,
    output dir_e                           dir_o
);

    logic signed [COORD_W-1:0] off_x, off_y;
    logic signed [COORD_W-1:0] px, py, col, row;
    logic                      row_neg, row_high, col_out;

    // NOTE: every output of a combinational block gets a default first, so
    // an index outside the table can never leave a latch behind.
    always_comb begin
        off_x = '0;
        off_y = '0;
        dir_o = DIR_UP;
        case (idx_i)
            4'd0:  begin off_x = '0;                  off_y = -COORD_W'(1);       dir_o = DIR_UP;    end
            4'd1:  begin off_x = COORD_W'(CHAR_W - 1); off_y = -COORD_W'(1);       dir_o = DIR_UP;    end
            4'd2:  begin off_x = '0;                  off_y = COORD_W'(CHAR_H);     dir_o = DIR_DOWN;  end
            4'd3:  begin off_x = COORD_W'(CHAR_W - 1); off_y = COORD_W'(CHAR_H);     dir_o = DIR_DOWN;  end
            4'd4:  begin off_x = -COORD_W'(1);       off_y = '0;                  dir_o = DIR_LEFT;  end
            4'd5:  begin off_x = -COORD_W'(1);       off_y = COORD_W'(CHAR_H - 1); dir_o = DIR_LEFT;  end
            4'd6:  begin off_x = COORD_W'(CHAR_W);     off_y = '0;                  dir_o = DIR_RIGHT; end
            4'd7:  begin off_x = COORD_W'(CHAR_W);     off_y = COORD_W'(CHAR_H - 1); dir_o = DIR_RIGHT; end
`ifdef COLLISION_MIDPOINT_EN
            4'd8:  begin off_x = -COORD_W'(1);       off_y = COORD_W'(CHAR_H / 2); dir_o = DIR_LEFT;  end
            4'd9:  begin off_x = COORD_W'(CHAR_W);     off_y = COORD_W'(CHAR_H / 2); dir_o = DIR_RIGHT; end
            4'd10: begin off_x = COORD_W'(CHAR_W / 2); off_y = -COORD_W'(1);       dir_o = DIR_UP;    end
            4'd11: begin off_x = COORD_W'(CHAR_W / 2); off_y = COORD_W'(CHAR_H);     dir_o = DIR_DOWN;  end
`endif
            default: begin off_x = '0; off_y = '0; dir_o = DIR_UP; end
        endcase
    end

    assign px  = $signed({1'b0, wx_i}) + off_x;
    assign py  = $signed({3'b000, y_i}) + off_y;
    assign col = px >>> TILE_SHIFT;
    assign row = py >>> TILE_SHIFT;

    // Above the map is open sky; below it is floor and beside it is wall.
    assign row_neg  = row[COORD_W-1];
    assign row_high = !row_neg && (row >= COORD_W'(MAP_ROWS));
    assign col_out  = col[COORD_W-1] || (col >= COORD_W'(1 << MAP_COLS_LOG2));

    assign in_map_o = !row_neg && !row_high && !col_out;
    assign forced_o = !row_neg;
    assign addr_o   = {row[ROW_W-1:0], col[MAP_COLS_LOG2-1:0]};

endmodule

// File: rtl/collision_detector.sv
// Scans the tile map around the character once per enable and latches the
// four blocked flags. Build option: COLLISION_MIDPOINT_EN (12-probe scan).
module collision_detector
    import collision_pkg::*;
#(
    parameter int CHAR_W        = CHAR_W_DEF,
    parameter int CHAR_H        = CHAR_H_DEF,
    parameter int TILE_SHIFT    = TILE_SHIFT_DEF,
    parameter int MAP_COLS_LOG2 = MAP_COLS_LOG2_DEF,
    parameter int MAP_ROWS      = MAP_ROWS_DEF,
    parameter int ADDR_W        = $clog2(MAP_ROWS) + MAP_COLS_LOG2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic [7:0]        x_position,
    input  logic [7:0]        y_position,
    input  logic [8:0]        scroll_x,
    output logic [ADDR_W-1:0] map_addr,
    output logic              map_rd,
    input  logic              map_data,
    output logic              left_blocked,
    output logic              right_blocked,
    output logic              up_blocked,
    output logic              down_blocked,
    output logic              busy,
    output logic              scan_done
);

    state_e             state_q, state_d;
    logic [WX_W-1:0]    wx_q;
    logic [7:0]         y_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         flags_q;
    logic               pend_vld_q, pend_in_map_q, pend_forced_q;
    dir_e               pend_dir_q;
    logic               pend_val;

    logic [ADDR_W-1:0]  pr_addr;
    logic               pr_in_map, pr_forced;
    dir_e               pr_dir;
    logic               last_probe;

    collision_probe_gen #(
        .CHAR_W        (CHAR_W),
        .CHAR_H        (CHAR_H),
        .TILE_SHIFT    (TILE_SHIFT),
        .MAP_COLS_LOG2 (MAP_COLS_LOG2),
        .MAP_ROWS      (MAP_ROWS)
    ) u_probe_gen (
        .idx_i    (idx_q),
        .wx_i     (wx_q),
        .y_i      (y_q),
        .addr_o   (pr_addr),
        .in_map_o (pr_in_map),
        .forced_o (pr_forced),
        .dir_o    (pr_dir)
    );

    assign last_probe = (idx_q == IDX_W'(PROBE_COUNT - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PROBE;
            ST_PROBE: if (last_probe) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        scan_done = (state_q == ST_DONE);
        map_rd    = (state_q == ST_PROBE) && pr_in_map;
        map_addr  = map_rd ? pr_addr : '0;
    end

    // The result returning this cycle belongs to the probe issued last cycle.
    assign pend_val = pend_in_map_q ? map_data : pend_forced_q;
    assign acc_d    = pend_vld_q ? (acc_q | (dir_mask(pend_dir_q) & {4{pend_val}})) : acc_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wx_q          <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            flags_q       <= '0;
            pend_vld_q    <= 1'b0;
            pend_in_map_q <= 1'b0;
            pend_forced_q <= 1'b0;
            pend_dir_q    <= DIR_UP;
        end else begin
            if (state_q == ST_IDLE && enable) begin
                wx_q <= WX_W'(x_position) + WX_W'(scroll_x);
                y_q  <= y_position;
            end
            idx_q         <= (state_q == ST_PROBE) ? idx_q + IDX_W'(1) : '0;
            pend_vld_q    <= (state_q == ST_PROBE);
            pend_in_map_q <= pr_in_map;
            pend_forced_q <= pr_forced;
            pend_dir_q    <= pr_dir;
            acc_q         <= (state_q == ST_IDLE) ? '0 : acc_d;
            // Flags move once, on entry to DONE, carrying the final result.
            if (state_q == ST_DRAIN) flags_q <= acc_d;
        end
    end

    assign up_blocked    = flags_q[DIR_UP];
    assign down_blocked  = flags_q[DIR_DOWN];
    assign left_blocked  = flags_q[DIR_LEFT];
    assign right_blocked = flags_q[DIR_RIGHT];

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Produces the left/right/up/down blocked flags consumed by the character movement block.
- Once per scan request it probes a tile-map memory around the character's bounding box, then latches the four flags.
- Sits between the level tile-map ROM (synchronous read port) and character movement.
- Flags stay stable between scans, so movement logic sees a consistent snapshot for a whole frame.

Parameters:
- CHAR_W, 8, character width in pixels
- CHAR_H, 16, character height in pixels
- TILE_SHIFT, 3, log2 of tile edge in pixels (8x8 tiles)
- MAP_COLS_LOG2, 6, log2 of map width in tiles (64)
- MAP_ROWS, 15, map height in tiles (120 px screen)

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  scan request pulse, e.g. frame tick
- x_position  in  8  character left edge, screen pixels
- y_position  in  8  character top edge, screen pixels
- scroll_x  in  9  world x of screen column 0
- map_addr  out  10  tile address {row[3:0], col[5:0]}
- map_rd  out  1  read strobe; data valid the next cycle
- map_data  in  1  1 = solid tile
- left_blocked  out  1  latched flag
- right_blocked  out  1  latched flag
- up_blocked  out  1  latched flag
- down_blocked  out  1  latched flag
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when flags update

Behaviour:
- Reset, asynchronous: state IDLE; all four flags 0; busy 0; scan_done 0; map_rd 0; map_addr 0.
- Coordinate snapshot: on accept, capture wx = x_position + scroll_x (10-bit) and y = y_position.
  - Probes are computed in signed 11-bit arithmetic so that -1 and edge+size do not wrap.
- Probe order, index 0..7:
  - up: (wx, y-1), (wx+W-1, y-1)
  - down: (wx, y+H), (wx+W-1, y+H)
  - left: (wx-1, y), (wx-1, y+H-1)
  - right: (wx+W, y), (wx+W, y+H-1)
- Out-of-map probes issue no read; the result is forced:
  - row < 0: not solid.
  - row >= MAP_ROWS: solid (floor).
  - col < 0 or col >= 64: solid.
- FSM:
  - IDLE: enable=1 -> PROBE, busy=1, probe index 0. enable while busy is ignored, not queued.
  - PROBE: one probe per cycle; map_rd asserted for in-map probes. Result of probe k arrives at cycle k+1 and is ORed into the accumulator for its direction. After the last issue -> DRAIN.
  - DRAIN: capture the final result -> DONE.
  - DONE: load the four flags from the accumulators, pulse scan_done for 1 cycle, busy=0 -> IDLE.
- Latency: enable sampled at cycle 0; flags valid and scan_done high at cycle 10 (8 probes + drain + done). With COLLISION_MIDPOINT_EN, cycle 14.
- Flags change only in DONE; a scan never produces partial updates.
- Input changes during a scan have no effect because coordinates are snapshotted.
- Reset mid-scan: immediate return to IDLE, flags cleared, the in-flight read result discarded.
- Simultaneous enable and DONE: the request is ignored (busy is still 1 in DONE); the next enable is needed.

Optional Feature:
- COLLISION_MIDPOINT_EN defined:
  - Adds mid-height probes (wx-1, y+H/2) and (wx+W, y+H/2), plus mid-width probes (wx+W/2, y-1) and (wx+W/2, y+H).
  - 12 probes total, catching tiles narrower than the character.
- Undefined: 8 probes only, as above.

Decomposition:
- Package collision_pkg holds:
  - state encoding IDLE/PROBE/DRAIN/DONE
  - direction encoding UP/DOWN/LEFT/RIGHT
  - probe count constant, set per macro
  - tile geometry constants
- Sub-module collision_probe_gen: combinational; maps probe index plus snapshot to {addr, in_map, forced_value, direction}.

Test Plan:
- Empty map, x=72, y=40, scroll=0, enable pulse -> scan_done at cycle 10; all flags 0; exactly 8 map_rd pulses.
- Solid row 10 (y 80..87), y=64 -> down probe at y=80 hits; down_blocked=1, others 0.
- y=0 with row 0 solid -> up probe at row -1 is out-of-map not-solid; up_blocked=0 and no map_rd issued for the up probes.
- scroll_x=504, x=0 -> right probe at col 64 is out of range, forced solid; right_blocked=1.
- Reset asserted at cycle 4 of a scan with down solid -> flags 0 immediately, busy 0; a fresh enable then completes normally.
- enable held high for 20 cycles -> exactly two scans (accepted at cycles 0 and 11), inputs changed mid-scan ignored.
